word_scorer: RTL and testbench

- Sequential, parametrised successor to the combinational colour scorer in the Wordle datapath.
- Scores one guess row against the chosen word and returns the same packed row format with yellow/green tags filled in.
- Uses standard Wordle duplicate-letter rules: each answer letter may be credited at most once, and greens take priority.
- Sits between the keyboard/row-entry logic and the VGA row renderer; triggered by a start/done handshake.

---
 rtl/word_scorer_if.sv | 43 ++++
 rtl/word_scorer.sv | 172 +++++++++++++++++
 tb/tb_word_scorer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_scorer_if.sv
// ============================================================================
// Module      : word_scorer_if
// Description : Start/done handshake and row bus between the row-entry logic
//               (master) and the word scorer (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   start        master->slave  one-cycle scoring request
//   input_row    master->slave  guess row, slots packed {yellow, green, letter}
//   chosen_word  master->slave  answer letters, letter 0 in the low bits
//   busy         slave->master  scoring in progress
//   done         slave->master  one-cycle pulse, output_row/win valid
//   output_row   slave->master  scored row
//   win          slave->master  every slot green
// ============================================================================
`default_nettype none

interface word_scorer_if #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 5
);
  localparam int SLOT_W = LETTER_W + 2;

  logic                            start;
  logic [NUM_LETTERS*SLOT_W-1:0]   input_row;
  logic [NUM_LETTERS*LETTER_W-1:0] chosen_word;
  logic                            busy;
  logic                            done;
  logic [NUM_LETTERS*SLOT_W-1:0]   output_row;
  logic                            win;

  modport master (
    output start, input_row, chosen_word,
    input  busy, done, output_row, win
  );

  modport slave (
    input  start, input_row, chosen_word,
    output busy, done, output_row, win
  );
endinterface

`default_nettype wire

// File: rtl/word_scorer.sv
// ============================================================================
// Module      : word_scorer
// Description : Sequential Wordle row scorer. Tags each guess slot green
//               (exact position) or yellow (letter elsewhere in the answer)
//               using standard duplicate-letter rules: greens are credited
//               first, then yellows left to right, each answer letter used
//               at most once. Letter code 0 is blank and never matches.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of word_scorer_if (start/input_row/chosen_word in,
//               busy/done/output_row/win out)
// Timing: start edge = cycle 0, GREEN cycles 1..N, YELLOW N+1..2N,
//         done high in cycle 2N+1.
// ============================================================================
`default_nettype none

module word_scorer #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 5
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  word_scorer_if.slave bus
);

  localparam int SLOT_W = LETTER_W + 2;
  localparam int IDX_W  = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LETTERS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]    idx;
  logic [LETTER_W-1:0] guess  [NUM_LETTERS];
  logic [LETTER_W-1:0] answer [NUM_LETTERS];
  logic [NUM_LETTERS-1:0] green, yellow, consumed;
  logic [NUM_LETTERS*SLOT_W-1:0] output_row_q;
  logic                          win_q;

  logic [LETTER_W-1:0]    cur_guess, cur_answer;
  logic                   is_last;
  logic                   green_hit, yellow_hit;
  logic                   match_found;
  logic [NUM_LETTERS-1:0] match_oh;
  logic [NUM_LETTERS-1:0] yellow_set;
  logic [NUM_LETTERS*SLOT_W-1:0] row_next;

  assign cur_guess  = guess[idx];
  assign cur_answer = answer[idx];
  assign is_last    = (idx == LAST_IDX);
  assign green_hit  = (cur_guess != '0) && (cur_guess == cur_answer);

  // Lowest still-unconsumed answer position holding the current guess letter.
  always_comb begin
    match_oh    = '0;
    match_found = 1'b0;
    for (int j = 0; j < NUM_LETTERS; j++) begin
      if (!match_found && !consumed[j] && (answer[j] == cur_guess)) begin
        match_oh[j] = 1'b1;
        match_found = 1'b1;
      end
    end
  end

  assign yellow_hit = (state == YELLOW) && !green[idx] &&
                      (cur_guess != '0) && match_found;

  // Yellow tags including the slot being scored this cycle, so the final
  // YELLOW cycle can load the complete row while entering DONE.
  always_comb begin
    yellow_set = yellow;
    if (yellow_hit) begin
      yellow_set[idx] = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_LETTERS; i++) begin : g_row
      assign row_next[i*SLOT_W +: SLOT_W] = {yellow_set[i], green[i], guess[i]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = GREEN;
      GREEN:   if (is_last)   state_next = YELLOW;
      YELLOW:  if (is_last)   state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      green        <= '0;
      yellow       <= '0;
      consumed     <= '0;
      output_row_q <= '0;
      win_q        <= 1'b0;
      for (int i = 0; i < NUM_LETTERS; i++) begin
        guess[i]  <= '0;
        answer[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < NUM_LETTERS; i++) begin
              guess[i]  <= bus.input_row[i*SLOT_W +: LETTER_W];
              answer[i] <= bus.chosen_word[i*LETTER_W +: LETTER_W];
            end
            green    <= '0;
            yellow   <= '0;
            consumed <= '0;
            idx      <= '0;
          end
        end
        GREEN: begin
          if (green_hit) begin
            green[idx]    <= 1'b1;
            consumed[idx] <= 1'b1;
          end
          idx <= is_last ? '0 : idx + 1'b1;
        end
        YELLOW: begin
          if (yellow_hit) begin
            yellow[idx] <= 1'b1;
            consumed    <= consumed | match_oh;
          end
          if (is_last) begin
            output_row_q <= row_next;
            win_q        <= &green;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.output_row = output_row_q;
  assign bus.win        = win_q;

endmodule

`default_nettype wire

// File: tb/tb_word_scorer.sv
// ============================================================================
// Module      : tb_word_scorer
// Description : Self-checking bench for word_scorer (N=5 and N=6 instances),
//               with a letter-pool reference model of the scoring rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_word_scorer;

  localparam int LW     = 5;
  localparam int SW     = LW + 2;
  localparam int N5     = 5;
  localparam int N6     = 6;
  localparam int MAXN   = 8;
  localparam int ROWW   = MAXN * SW;
  localparam int WORDW  = MAXN * LW;
  localparam int BUDGET = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  word_scorer_if #(.NUM_LETTERS(N5), .LETTER_W(LW)) bus5 ();
  word_scorer_if #(.NUM_LETTERS(N6), .LETTER_W(LW)) bus6 ();

  word_scorer #(.NUM_LETTERS(N5), .LETTER_W(LW)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  word_scorer #(.NUM_LETTERS(N6), .LETTER_W(LW)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  // ---------------- reference model and helpers ----------------
  // Greens first; the remaining answer letters form a pool that yellows
  // draw from left to right.
  function automatic void model(input int n, input int g[MAXN], input int a[MAXN],
                                output logic [7:0] gm, output logic [7:0] ym);
    int pool[32];
    gm = '0;
    ym = '0;
    for (int k = 0; k < 32; k++) pool[k] = 0;
    for (int i = 0; i < n; i++) begin
      if (g[i] != 0 && g[i] == a[i]) gm[i] = 1'b1;
      else if (a[i] != 0) pool[a[i]]++;
    end
    for (int i = 0; i < n; i++) begin
      if (!gm[i] && g[i] != 0 && pool[g[i]] > 0) begin
        ym[i] = 1'b1;
        pool[g[i]]--;
      end
    end
  endfunction

  function automatic void str2arr(input string s, output int a[MAXN]);
    for (int k = 0; k < MAXN; k++) a[k] = (k < s.len()) ? (int'(s[k]) - 64) : 0;
  endfunction

  function automatic void rand_word(input int n, output int a[MAXN]);
    for (int k = 0; k < MAXN; k++)
      a[k] = (k >= n) ? 0 : (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4)));
  endfunction

  // Incoming tag bits are randomised: the scorer must ignore them.
  function automatic logic [ROWW-1:0] pack_row(input int n, input int g[MAXN]);
    logic [ROWW-1:0] r = '0;
    for (int k = 0; k < n; k++) r[k*SW +: SW] = {2'($urandom_range(0, 3)), LW'(g[k])};
    return r;
  endfunction

  function automatic logic [WORDW-1:0] pack_word(input int n, input int a[MAXN]);
    logic [WORDW-1:0] w = '0;
    for (int k = 0; k < n; k++) w[k*LW +: LW] = LW'(a[k]);
    return w;
  endfunction

  function automatic logic [ROWW-1:0] exp_row(input int n, input int g[MAXN],
                                              input logic [7:0] gm, input logic [7:0] ym);
    logic [ROWW-1:0] r = '0;
    for (int k = 0; k < n; k++) r[k*SW +: SW] = {ym[k], gm[k], LW'(g[k])};
    return r;
  endfunction

  // Drive one request; lat is the cycle in which done was seen (-1 on timeout).
  task automatic score5(input int g[MAXN], input int a[MAXN],
                        output logic [ROWW-1:0] got, output logic got_win, output int lat);
    logic [ROWW-1:0]  r;
    logic [WORDW-1:0] w;
    r = pack_row(N5, g);
    w = pack_word(N5, a);
    got = '0;
    got_win = 1'b0;
    lat = -1;
    @(negedge clk);
    bus5.input_row   = r[N5*SW-1:0];
    bus5.chosen_word = w[N5*LW-1:0];
    bus5.start       = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      bus5.start = 1'b0;
      if (bus5.done === 1'b1) begin
        lat = c;
        got[N5*SW-1:0] = bus5.output_row;
        got_win = bus5.win;
        break;
      end
    end
  endtask

  task automatic score6(input int g[MAXN], input int a[MAXN],
                        output logic [ROWW-1:0] got, output logic got_win, output int lat);
    logic [ROWW-1:0]  r;
    logic [WORDW-1:0] w;
    r = pack_row(N6, g);
    w = pack_word(N6, a);
    got = '0;
    got_win = 1'b0;
    lat = -1;
    @(negedge clk);
    bus6.input_row   = r[N6*SW-1:0];
    bus6.chosen_word = w[N6*LW-1:0];
    bus6.start       = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      bus6.start = 1'b0;
      if (bus6.done === 1'b1) begin
        lat = c;
        got[N6*SW-1:0] = bus6.output_row;
        got_win = bus6.win;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (bus5.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus5.busy); end
    vectors++; if (bus5.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus5.done); end
    vectors++; if (bus5.win !== 1'b0) begin miscompares++; $display("FAIL reset_win: got %b want 0", bus5.win); end
    vectors++; if (bus5.output_row !== '0) begin miscompares++; $display("FAIL reset_row: got %h want 0", bus5.output_row); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input string gs, input string as,
                               input logic [7:0] gm, input logic [7:0] ym, input logic want_win);
    int g[MAXN], a[MAXN];
    logic [ROWW-1:0] got, want;
    logic w;
    int lat;
    str2arr(gs, g);
    str2arr(as, a);
    want = exp_row(N5, g, gm, ym);
    score5(g, a, got, w, lat);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL %s_latency: got %0d want 11", name, lat); end
    vectors++; if (got !== want) begin miscompares++; $display("FAIL %s_row: got %h want %h", name, got, want); end
    vectors++; if (w !== want_win) begin miscompares++; $display("FAIL %s_win: got %b want %b", name, w, want_win); end
  endtask

  task automatic test_reset_mid();
    int g[MAXN], a[MAXN];
    int dones = 0;
    str2arr("CRANE", g);
    str2arr("TRACE", a);
    @(negedge clk);
    bus5.input_row   = pack_row(N5, g)[N5*SW-1:0];
    bus5.chosen_word = pack_word(N5, a)[N5*LW-1:0];
    bus5.start       = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus5.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus5.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", bus5.busy); end
    vectors++; if (bus5.win !== 1'b0) begin miscompares++; $display("FAIL midreset_win: got %b want 0", bus5.win); end
    vectors++; if (bus5.output_row !== '0) begin miscompares++; $display("FAIL midreset_row: got %h want 0", bus5.output_row); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus5.done === 1'b1) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL midreset_nodone: got %0d pulses want 0", dones); end
  endtask

  task automatic test_handshake();
    int g[MAXN], a[MAXN], g2[MAXN], a2[MAXN];
    logic [7:0] gm, ym;
    logic [ROWW-1:0] want, got, r;
    logic [WORDW-1:0] wd;
    logic gw = 1'b0;
    int dones = 0, lat = -1;
    rand_word(N5, g);
    rand_word(N5, a);
    rand_word(N5, g2);
    rand_word(N5, a2);
    model(N5, g, a, gm, ym);
    want = exp_row(N5, g, gm, ym);
    got = '0;
    r  = pack_row(N5, g);
    wd = pack_word(N5, a);
    @(negedge clk);
    bus5.input_row   = r[N5*SW-1:0];
    bus5.chosen_word = wd[N5*LW-1:0];
    bus5.start       = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus5.start = (c == 3 || c == 11);
      if (c == 1) begin
        vectors++; if (bus5.busy !== 1'b1) begin miscompares++; $display("FAIL hs_busy: got %b want 1", bus5.busy); end
        r  = pack_row(N5, g2);
        wd = pack_word(N5, a2);
        bus5.input_row   = r[N5*SW-1:0];
        bus5.chosen_word = wd[N5*LW-1:0];
      end
      if (bus5.done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          got[N5*SW-1:0] = bus5.output_row;
          gw = bus5.win;
        end
      end
    end
    bus5.start = 1'b0;
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL hs_pulses: got %0d want 1", dones); end
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL hs_latency: got %0d want 11", lat); end
    vectors++; if (got !== want) begin miscompares++; $display("FAIL hs_row: got %h want %h", got, want); end
    vectors++; if (gw !== (gm[4:0] == 5'h1F)) begin miscompares++; $display("FAIL hs_win: got %b want %b", gw, gm[4:0] == 5'h1F); end
    vectors++; if (bus5.busy !== 1'b0) begin miscompares++; $display("FAIL hs_idle: got busy %b want 0", bus5.busy); end
  endtask

  task automatic test_random5();
    int g[MAXN], a[MAXN];
    logic [7:0] gm, ym;
    logic [ROWW-1:0] got, want;
    logic w;
    int lat;
    for (int t = 0; t < 20; t++) begin
      rand_word(N5, g);
      if (t % 4 == 0) a = g; else rand_word(N5, a);
      model(N5, g, a, gm, ym);
      want = exp_row(N5, g, gm, ym);
      score5(g, a, got, w, lat);
      vectors++; if (lat !== 11) begin miscompares++; $display("FAIL rand5_latency[%0d]: got %0d want 11", t, lat); end
      vectors++; if (got !== want) begin miscompares++; $display("FAIL rand5_row[%0d]: got %h want %h", t, got, want); end
      vectors++; if (w !== (gm[4:0] == 5'h1F)) begin miscompares++; $display("FAIL rand5_win[%0d]: got %b want %b", t, w, gm[4:0] == 5'h1F); end
    end
  endtask

  task automatic test_sweep_n6();
    int g[MAXN], a[MAXN];
    logic [7:0] gm, ym;
    logic [ROWW-1:0] got, want;
    logic w;
    int lat;
    for (int t = 0; t < 20; t++) begin
      rand_word(N6, g);
      if (t % 4 == 0) a = g; else rand_word(N6, a);
      model(N6, g, a, gm, ym);
      want = exp_row(N6, g, gm, ym);
      score6(g, a, got, w, lat);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL n6_latency[%0d]: got %0d want 13", t, lat); end
      vectors++; if (got !== want) begin miscompares++; $display("FAIL n6_row[%0d]: got %h want %h", t, got, want); end
      vectors++; if (w !== (gm[5:0] == 6'h3F)) begin miscompares++; $display("FAIL n6_win[%0d]: got %b want %b", t, w, gm[5:0] == 6'h3F); end
    end
  endtask

  initial begin
    bus5.start = 1'b0; bus5.input_row = '0; bus5.chosen_word = '0;
    bus6.start = 1'b0; bus6.input_row = '0; bus6.chosen_word = '0;
    test_reset();
    test_directed("exact",     "CRANE", "CRANE", 8'h1F, 8'h00, 1'b1);
    test_reset_mid();
    test_directed("dup",       "BOBBY", "ABBEY", 8'h14, 8'h01, 1'b0);
    // THREE keeps only one E after the slot-4 green, so only slot 0 turns yellow.
    test_directed("greenprio", "EERIE", "THREE", 8'h14, 8'h01, 1'b0);
    test_directed("blank",     "",      "CRANE", 8'h00, 8'h00, 1'b0);
    test_directed("nomatch",   "QUICK", "CRANE", 8'h00, 8'h08, 1'b0);
    test_handshake();
    test_random5();
    test_sweep_n6();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
